// File: rtl/clock_div_ctrl_if.sv
// Configuration and status bundle for clock_div_ctrl.
// The master side (register/config logic) offers new half-period counts
// over a valid/ready handshake and drives the run enable; the slave side
// (the divider) returns the divided clock, its rise tick and status.
interface clock_div_ctrl_if #(
    parameter int CNT_W = 25
);
    logic             en_in;
    logic             cfg_valid_in;
    logic [CNT_W-1:0] cfg_half_in;
    logic             cfg_ready_out;
    logic             clk_out;
    logic             tick_out;
    logic             busy_out;
    logic [CNT_W-1:0] half_out;

    modport master (
        output en_in,
        output cfg_valid_in,
        output cfg_half_in,
        input  cfg_ready_out,
        input  clk_out,
        input  tick_out,
        input  busy_out,
        input  half_out
    );

    modport slave (
        input  en_in,
        input  cfg_valid_in,
        input  cfg_half_in,
        output cfg_ready_out,
        output clk_out,
        output tick_out,
        output busy_out,
        output half_out
    );
endinterface

// File: rtl/clock_div_ctrl.sv
// Runtime-programmable clock divider with glitch-free start/stop.
// clk_out has a period of 2*(half_out+1) clk_in cycles at 50% duty.
// New half-period counts are parked in a shadow register and only take
// effect on a 1->0 edge of clk_out, so a ratio change never produces a
// runt pulse. While stopped (IDLE) a new count is written straight into
// the active register because no output phase is in progress.
module clock_div_ctrl #(
    parameter int               CNT_W      = 25,
    parameter logic [CNT_W-1:0] RESET_HALF = CNT_W'(25_000_000 - 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    clock_div_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] half, half_nxt;
    logic [CNT_W-1:0] shadow, shadow_nxt;
    logic             pending, pending_nxt;
    logic             clk_q, clk_nxt;
    logic             tick_q, tick_nxt;

    logic             accept;
    logic             at_half;

    // A config is taken only while nothing is waiting to be applied.
    assign accept  = bus.cfg_valid_in && !pending;
    assign at_half = (count == half);

    // Next-state and datapath decode for the IDLE/RUN/DRAIN controller.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_nxt   = state;
        count_nxt   = count;
        half_nxt    = half;
        shadow_nxt  = shadow;
        pending_nxt = pending;
        clk_nxt     = clk_q;
        tick_nxt    = 1'b0;

        case (state)
            IDLE: begin
                count_nxt = '0;
                clk_nxt   = 1'b0;
                if (accept) begin
                    half_nxt = bus.cfg_half_in;
                end
                if (bus.en_in) begin
                    state_nxt = RUN;
                end
            end

            RUN, DRAIN: begin
                // Shared counting: toggle at the terminal count, and on a
                // falling toggle promote any parked ratio so the new low
                // phase already uses it.
                if (at_half) begin
                    count_nxt = '0;
                    clk_nxt   = !clk_q;
                    tick_nxt  = !clk_q;
                    if (clk_q && pending) begin
                        half_nxt    = shadow;
                        pending_nxt = 1'b0;
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end

                if (accept) begin
                    shadow_nxt  = bus.cfg_half_in;
                    pending_nxt = 1'b1;
                end

                if (state == RUN) begin
                    if (!bus.en_in) begin
                        state_nxt = DRAIN;
                    end
                end else if (bus.en_in) begin
                    // Re-enabled before the drain finished: keep counting.
                    state_nxt = RUN;
                end else if (!clk_q || at_half) begin
                    // Stopping: either the output is already low, or this
                    // edge is the 1->0 toggle. Hold the output low, and make
                    // sure no ratio is left parked since IDLE never applies
                    // the shadow register.
                    state_nxt = IDLE;
                    count_nxt = '0;
                    clk_nxt   = 1'b0;
                    tick_nxt  = 1'b0;
                    if (accept) begin
                        half_nxt    = bus.cfg_half_in;
                        shadow_nxt  = shadow;
                        pending_nxt = 1'b0;
                    end else if (pending) begin
                        half_nxt    = shadow;
                        pending_nxt = 1'b0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
                clk_nxt   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset stops the output immediately.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            count   <= '0;
            half    <= RESET_HALF;
            shadow  <= '0;
            pending <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state   <= state_nxt;
            count   <= count_nxt;
            half    <= half_nxt;
            shadow  <= shadow_nxt;
            pending <= pending_nxt;
            clk_q   <= clk_nxt;
            tick_q  <= tick_nxt;
        end
    end

    assign bus.cfg_ready_out = !pending;
    assign bus.busy_out      = pending;
    assign bus.half_out      = half;
    assign bus.clk_out       = clk_q;
    assign bus.tick_out      = tick_q;

    // Structural invariants of the divider.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            assert (count <= half)
                else $error("count exceeded active half-period");
            assert (!tick_q || clk_q)
                else $error("tick asserted while clk_out low");
            assert (!(state == IDLE && pending))
                else $error("config parked while stopped");
            assert (!(state == IDLE && clk_q))
                else $error("clk_out high while stopped");
        end
    end

endmodule
